// File: rtl/pe_conv_sched.sv
// Sequencer for one 1-D convolution layer on a single combinational PE.
// Builds the tap window from activation memory with stride/padding, then streams one result per channel.
module pe_conv_sched #(
    parameter int WIDTH  = 32,
    parameter int N_REG  = 31,
    parameter int ADDR_W = 12,
    parameter int CH_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_in_len,
    input  logic [ADDR_W-1:0]      cfg_out_len,
    input  logic [ADDR_W-1:0]      cfg_stride,
    input  logic [ADDR_W-1:0]      cfg_pad,
    input  logic [CH_W-1:0]        cfg_n_ch,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [WIDTH-1:0]       rd_data,
    output logic [N_REG*WIDTH-1:0] all_a,
    output logic [CH_W-1:0]        ch_sel,
    input  logic [WIDTH-1:0]       pe_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ADDR_W-1:0]      out_pos,
    output logic [CH_W-1:0]        out_ch,
    output logic                   busy,
    output logic                   done
);
    // state     | meaning
    // S_IDLE    | waiting for start, config not latched
    // S_FILL    | one window slot per cycle, plus one drain cycle for the last read
    // S_COMPUTE | PE result for (pos, ch) captured into out_data
    // S_EMIT    | out_valid held until out_ready
    // S_DONE    | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_COMPUTE, S_EMIT, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        in_len, out_len, stride;
    logic [CH_W-1:0]          n_ch, ch;
    logic [ADDR_W-1:0]        pos;
    logic [ADDR_W-1:0]        slots;
    logic signed [ADDR_W:0]   idx;
    logic                     shift_pend, pad_pend;
    logic [N_REG*WIDTH-1:0]   win;
    logic                     slot_act, in_range, last_ch, last_pos;

    // idx is the next input index to fetch; it keeps running across positions
    // so an advance only fetches the S samples that are new to the window.
    assign slot_act = (state == S_FILL) && (slots != '0);
    assign in_range = !idx[ADDR_W] && (idx < $signed({1'b0, in_len}));
    assign last_ch  = (ch == n_ch - CH_W'(1));
    assign last_pos = (pos == out_len - ADDR_W'(1));
    assign all_a    = win;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FILL;
            S_FILL:    if (slots == '0) state_nxt = S_COMPUTE;
            S_COMPUTE: state_nxt = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    if (!last_ch)       state_nxt = S_COMPUTE;
                    else if (!last_pos) state_nxt = S_FILL;
                    else                state_nxt = S_DONE;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en     = slot_act && in_range;
        rd_addr   = rd_en ? idx[ADDR_W-1:0] : '0;
        out_valid = (state == S_EMIT);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        ch_sel    = (state == S_IDLE || state == S_DONE) ? '0 : ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_len     <= '0;
            out_len    <= '0;
            stride     <= '0;
            n_ch       <= '0;
            ch         <= '0;
            pos        <= '0;
            slots      <= '0;
            idx        <= '0;
            shift_pend <= 1'b0;
            pad_pend   <= 1'b0;
            win        <= '0;
            out_data   <= '0;
            out_pos    <= '0;
            out_ch     <= '0;
        end else begin
            shift_pend <= slot_act;
            pad_pend   <= !in_range;
            // Read data lands one cycle after its slot, so the shift lags the slot by one.
            if (shift_pend)
                win <= {(pad_pend ? {WIDTH{1'b0}} : rd_data), win[N_REG*WIDTH-1:WIDTH]};

            if (state == S_IDLE && start) begin
                in_len  <= cfg_in_len;
                out_len <= cfg_out_len;
                stride  <= cfg_stride;
                n_ch    <= cfg_n_ch;
                ch      <= '0;
                pos     <= '0;
                slots   <= ADDR_W'(N_REG);
                idx     <= -$signed({1'b0, cfg_pad});
                win     <= '0;
            end

            if (slot_act) begin
                slots <= slots - ADDR_W'(1);
                idx   <= idx + (ADDR_W+1)'(1);
            end

            if (state == S_COMPUTE) begin
                out_data <= pe_y;
                out_pos  <= pos;
                out_ch   <= ch;
            end

            if (state == S_EMIT && out_ready) begin
                if (!last_ch) begin
                    ch <= ch + CH_W'(1);
                end else if (!last_pos) begin
                    ch    <= '0;
                    pos   <= pos + ADDR_W'(1);
                    slots <= stride;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_conv_sched.sv
// Directed bench for pe_conv_sched with N_REG=3, a sum-of-taps PE model
// (+100 per channel) and a one-cycle-latency activation memory.
module tb_pe_conv_sched;
    localparam int WIDTH  = 32;
    localparam int N_REG  = 3;
    localparam int ADDR_W = 12;
    localparam int CH_W   = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [ADDR_W-1:0]      cfg_in_len = '0, cfg_out_len = '0, cfg_stride = '0, cfg_pad = '0;
    logic [CH_W-1:0]        cfg_n_ch = '0;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [WIDTH-1:0]       rd_data = '0;
    logic [N_REG*WIDTH-1:0] all_a;
    logic [CH_W-1:0]        ch_sel;
    logic [WIDTH-1:0]       pe_y;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [WIDTH-1:0]       out_data;
    logic [ADDR_W-1:0]      out_pos;
    logic [CH_W-1:0]        out_ch;
    logic                   busy, done;

    pe_conv_sched #(.WIDTH(WIDTH), .N_REG(N_REG), .ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_stride(cfg_stride),
        .cfg_pad(cfg_pad), .cfg_n_ch(cfg_n_ch),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .all_a(all_a), .ch_sel(ch_sel), .pe_y(pe_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pos(out_pos), .out_ch(out_ch), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [0:15];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

    always_comb begin
        pe_y = '0;
        for (int k = 0; k < N_REG; k++) pe_y = pe_y + all_a[k*WIDTH +: WIDTH];
        pe_y = pe_y + 32'(ch_sel) * 32'd100;
    end

    int n_total = 0, n_bad = 0;
    int cyc = 0, start_cyc = -1, first_valid_cyc = -1;
    int n_done = 0, n_reads = 0, n_oob = 0, n_emit_rd = 0, n_unstable = 0;
    int cur_lin = 0;
    bit rnd_rdy = 1'b0;
    bit prev_stall = 1'b0;
    logic [WIDTH-1:0]  prev_d;
    logic [ADDR_W-1:0] prev_p;
    logic [CH_W-1:0]   prev_c;
    int q_d[$], q_p[$], q_c[$];
    int exp_sums[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (start && !busy && start_cyc < 0) start_cyc = cyc;
        if (done) n_done++;
        if (rd_en) begin
            n_reads++;
            if (int'(rd_addr) >= cur_lin) n_oob++;
            if (out_valid) n_emit_rd++;
        end
        if (out_valid && prev_stall &&
            (out_data !== prev_d || out_pos !== prev_p || out_ch !== prev_c)) n_unstable++;
        prev_stall = out_valid && !out_ready;
        prev_d = out_data; prev_p = out_pos; prev_c = out_ch;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
            q_d.push_back(int'(out_data));
            q_p.push_back(int'(out_pos));
            q_c.push_back(int'(out_ch));
        end
    end

    task automatic clear_obs();
        q_d.delete(); q_p.delete(); q_c.delete();
        n_done = 0; n_reads = 0; n_oob = 0; n_emit_rd = 0; n_unstable = 0;
        start_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic run_layer(input string tag, input int lin, input int lout, input int s,
                             input int p, input int c, input bit rnd, input bit extra_start,
                             input int exp_reads, input bit chk_lat);
        int k;
        clear_obs();
        cur_lin = lin;
        rnd_rdy = rnd;
        cfg_in_len = ADDR_W'(lin); cfg_out_len = ADDR_W'(lout);
        cfg_stride = ADDR_W'(s);   cfg_pad = ADDR_W'(p); cfg_n_ch = CH_W'(c);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // config changes after latch must not matter
        cfg_in_len = '0; cfg_out_len = 12'd9; cfg_stride = 12'd3; cfg_n_ch = 8'd5;
        if (extra_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        k = 0;
        while (n_done == 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_timeout"}, 128'(k < 2000), 128'(1));
        repeat (6) @(posedge clk);
        rnd_rdy = 1'b0;
        chk({tag, "_done_cnt"}, 128'(n_done), 128'(1));
        chk({tag, "_reads"}, 128'(n_reads), 128'(exp_reads));
        chk({tag, "_rd_oob"}, 128'(n_oob), 128'(0));
        chk({tag, "_rd_in_emit"}, 128'(n_emit_rd), 128'(0));
        chk({tag, "_stall_stable"}, 128'(n_unstable), 128'(0));
        if (chk_lat) chk({tag, "_first_valid_lat"}, 128'(first_valid_cyc - start_cyc), 128'(N_REG + 3));
        chk({tag, "_count"}, 128'(q_d.size()), 128'(exp_sums.size() * c));
        for (int i = 0; i < q_d.size() && i < exp_sums.size() * c; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 128'(q_d[i]), 128'(exp_sums[i / c] + 100 * (i % c)));
            chk($sformatf("%s_pos%0d", tag, i), 128'(q_p[i]), 128'(i / c));
            chk($sformatf("%s_ch%0d", tag, i), 128'(q_c[i]), 128'(i % c));
        end
        chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_rd_en"}, 128'(rd_en), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_all_a"}, 128'(all_a), 128'(0));
        chk({tag, "_ch_sel"}, 128'(ch_sel), 128'(0));
        chk({tag, "_out_data"}, 128'(out_data), 128'(0));
        chk({tag, "_tags"}, 128'({out_pos, out_ch}), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = WIDTH'(i + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // S=1 P=1 windows {0,1,2},{1,2,3},{2,3,4},{3,4,0}
        exp_sums = '{3, 6, 9, 7};
        run_layer("basic", 4, 4, 1, 1, 1, 1'b0, 1'b0, 4, 1'b1);

        run_layer("multich", 4, 4, 1, 1, 3, 1'b0, 1'b0, 4, 1'b1);

        // S=2 P=0 windows {1,2,3},{3,4,5},{5,6,7}
        exp_sums = '{6, 12, 18};
        run_layer("stride2", 7, 3, 2, 0, 1, 1'b0, 1'b0, 7, 1'b1);

        exp_sums = '{3, 6, 9, 7};
        run_layer("backpr", 4, 4, 1, 1, 3, 1'b1, 1'b0, 4, 1'b0);

        // abort in the middle of FILL
        clear_obs();
        cfg_in_len = 12'd4; cfg_out_len = 12'd4; cfg_stride = 12'd1; cfg_pad = 12'd1; cfg_n_ch = 8'd1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        chk("midrst_no_done", 128'(n_done), 128'(0));
        run_layer("after_rst", 4, 4, 1, 1, 1, 1'b0, 1'b0, 4, 1'b1);

        run_layer("restart", 4, 4, 1, 1, 1, 1'b0, 1'b1, 4, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
